// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage; ready/valid data bus, load align/extend.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] store_data,
    input  logic [2:0]       funct3,
    input  logic             memRead,
    input  logic             memWrite,
    input  logic             memToReg_in,
    input  logic             regWrite_in,
    input  logic [4:0]       rd_in,
    output logic             stall_out,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_wstrb,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ready,
    output logic             wb_valid,
    output logic [WIDTH-1:0] data_read,
    output logic [WIDTH-1:0] alu_data,
    output logic             memToReg,
    output logic             regWrite,
    output logic [4:0]       rd,
    output logic             mem_fault
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;
    logic             r_is_load;
    logic [WIDTH-1:0] r_alu;
    logic             r_m2r;
    logic             r_rw;
    logic [4:0]       r_rd;

    logic [1:0]       w_off;
    logic             w_mem_op;
    logic             w_bad_f3;
    logic             w_misal;
    logic             w_fault;
    logic [3:0]       w_strb;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_lane;
    logic [WIDTH-1:0] w_load;

    assign w_off     = alu_result[1:0];
    assign w_mem_op  = memRead | memWrite;
    assign stall_out = (r_state == BUSY);

    always_comb begin
        w_bad_f3 = 1'b0;
        if (memWrite) begin
            w_bad_f3 = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            w_bad_f3 = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
        end
        w_misal = ((funct3[1:0] == 2'b01) && w_off[0]) ||
                  ((funct3[1:0] == 2'b10) && (w_off != 2'b00));
        w_fault = w_mem_op & ((memRead & memWrite) | w_bad_f3 | w_misal);
    end

    // Store data is replicated across lanes; the strobes select which lanes land.
    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = '0;
        if (memWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    w_strb  = 4'b0001 << w_off;
                    w_wdata = {4{store_data[7:0]}};
                end
                2'b01: begin
                    w_strb  = 4'b0011 << w_off;
                    w_wdata = {2{store_data[15:0]}};
                end
                default: begin
                    w_strb  = 4'b1111;
                    w_wdata = store_data;
                end
            endcase
        end
    end

    assign w_lane = dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{(WIDTH-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{(WIDTH-16){w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load = {{(WIDTH-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_load = {{(WIDTH-16){1'b0}}, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_is_load  <= 1'b0;
            r_alu      <= '0;
            r_m2r      <= 1'b0;
            r_rw       <= 1'b0;
            r_rd       <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= 4'b0000;
            wb_valid   <= 1'b0;
            data_read  <= '0;
            alu_data   <= '0;
            memToReg   <= 1'b0;
            regWrite   <= 1'b0;
            rd         <= 5'd0;
            mem_fault  <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            mem_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (!w_mem_op || w_fault) begin
                            // ALU results and faulting accesses retire without a bus cycle.
                            wb_valid  <= 1'b1;
                            mem_fault <= w_fault;
                            data_read <= '0;
                            alu_data  <= alu_result;
                            memToReg  <= memToReg_in;
                            regWrite  <= regWrite_in & ~w_fault;
                            rd        <= rd_in;
                        end else begin
                            r_state    <= BUSY;
                            dmem_req   <= 1'b1;
                            dmem_we    <= memWrite;
                            dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
                            dmem_wdata <= w_wdata;
                            dmem_wstrb <= w_strb;
                            r_funct3   <= funct3;
                            r_off      <= w_off;
                            r_is_load  <= memRead;
                            r_alu      <= alu_result;
                            r_m2r      <= memToReg_in;
                            r_rw       <= regWrite_in;
                            r_rd       <= rd_in;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        r_state    <= IDLE;
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        dmem_addr  <= '0;
                        dmem_wdata <= '0;
                        dmem_wstrb <= 4'b0000;
                        wb_valid   <= 1'b1;
                        data_read  <= r_is_load ? w_load : '0;
                        alu_data   <= r_alu;
                        memToReg   <= r_m2r;
                        regWrite   <= r_rw;
                        rd         <= r_rd;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: vector table plus WB scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        memRead;
    logic        memWrite;
    logic        memToReg_in;
    logic        regWrite_in;
    logic [4:0]  rd_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        wb_valid;
    logic [31:0] data_read;
    logic [31:0] alu_data;
    logic        memToReg;
    logic        regWrite;
    logic [4:0]  rd;
    logic        mem_fault;

    mem_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result),
        .store_data(store_data), .funct3(funct3), .memRead(memRead), .memWrite(memWrite),
        .memToReg_in(memToReg_in), .regWrite_in(regWrite_in), .rd_in(rd_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .wb_valid(wb_valid),
        .data_read(data_read), .alu_data(alu_data), .memToReg(memToReg),
        .regWrite(regWrite), .rd(rd), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [2:0]  f3;
        logic        rd_op;
        logic        wr_op;
        logic [31:0] rdata;
        int          waits;
        logic        fault;
        logic [31:0] exp_data;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] alu;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cur_id = -1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s (case %0d): got %h, expected %h", nm, cur_id, act, exp);
    endtask

    // Scoreboard: every wb_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("wb_data_read", data_read, e.data);
                check("wb_alu_data", alu_data, e.alu);
                check("wb_memToReg", {31'd0, memToReg}, {31'd0, e.m2r});
                check("wb_regWrite", {31'd0, regWrite}, {31'd0, e.rw});
                check("wb_rd", {27'd0, rd}, {27'd0, e.rd});
                check("wb_mem_fault", {31'd0, mem_fault}, {31'd0, e.fault});
                check("wb_cycle", cyc, e.cyc);
            end
        end else if (mem_fault === 1'b1) begin
            check("fault_without_wb", 32'd1, 32'd0);
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   stall_cnt;
        in_valid    = 1'b1;
        alu_result  = v.addr;
        store_data  = v.sdata;
        funct3      = v.f3;
        memRead     = v.rd_op;
        memWrite    = v.wr_op;
        memToReg_in = v.rd_op;
        regWrite_in = v.rd_op | v.fault;
        rd_in       = 5'(idx + 1);
        e.data  = v.exp_data;
        e.alu   = v.addr;
        e.m2r   = v.rd_op;
        e.rw    = v.rd_op & ~v.fault;
        e.rd    = 5'(idx + 1);
        e.fault = v.fault;
        e.cyc   = cyc + 1 + (v.fault ? 0 : 1 + v.waits);
        q.push_back(e);
        @(negedge clk);
        in_valid   = 1'b0;
        alu_result = $urandom;
        store_data = $urandom;
        funct3     = 3'(idx);
        if (v.fault) begin
            check("fault_no_req", {31'd0, dmem_req}, 32'd0);
            check("fault_no_stall", {31'd0, stall_out}, 32'd0);
        end else begin
            stall_cnt = 0;
            for (int w = 0; w <= v.waits; w++) begin
                check("bus_req", {31'd0, dmem_req}, 32'd1);
                check("bus_addr", dmem_addr, {v.addr[31:2], 2'b00});
                check("bus_we", {31'd0, dmem_we}, {31'd0, v.wr_op});
                check("bus_wstrb", {28'd0, dmem_wstrb}, {28'd0, v.exp_strb});
                check("bus_wdata", dmem_wdata, v.exp_wdata);
                if (stall_out === 1'b1) stall_cnt++;
                if (w == v.waits) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = v.rdata;
                end else begin
                    dmem_rdata = $urandom;
                end
                @(negedge clk);
            end
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
            check("stall_cycles", stall_cnt, v.waits + 1);
            check("stall_release", {31'd0, stall_out}, 32'd0);
            check("req_release", {31'd0, dmem_req}, 32'd0);
        end
    endtask

    vec_t vecs[18];

    initial begin
        //          addr          sdata         f3      rd    wr    rdata         w  flt   data          strb     wdata
        vecs[0]  = '{32'h100, 32'h0,        3'b010, 1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 4'b0000, 32'h0};
        vecs[1]  = '{32'h103, 32'h0,        3'b000, 1'b1, 1'b0, 32'h80123456, 0, 1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
        vecs[2]  = '{32'h103, 32'h0,        3'b100, 1'b1, 1'b0, 32'h80123456, 1, 1'b0, 32'h00000080, 4'b0000, 32'h0};
        vecs[3]  = '{32'h102, 32'h0,        3'b001, 1'b1, 1'b0, 32'h80123456, 0, 1'b0, 32'hFFFF8012, 4'b0000, 32'h0};
        vecs[4]  = '{32'h102, 32'h0,        3'b101, 1'b1, 1'b0, 32'h80123456, 2, 1'b0, 32'h00008012, 4'b0000, 32'h0};
        vecs[5]  = '{32'h101, 32'h0,        3'b000, 1'b1, 1'b0, 32'h11223344, 0, 1'b0, 32'h00000033, 4'b0000, 32'h0};
        vecs[6]  = '{32'h100, 32'h0,        3'b001, 1'b1, 1'b0, 32'h12347FFF, 0, 1'b0, 32'h00007FFF, 4'b0000, 32'h0};
        vecs[7]  = '{32'h201, 32'h123456A5, 3'b000, 1'b0, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 32'h0,        4'b0010, 32'hA5A5A5A5};
        vecs[8]  = '{32'h202, 32'h0000ABCD, 3'b001, 1'b0, 1'b1, 32'hFFFFFFFF, 3, 1'b0, 32'h0,        4'b1100, 32'hABCDABCD};
        vecs[9]  = '{32'h204, 32'h12345678, 3'b010, 1'b0, 1'b1, 32'hFFFFFFFF, 2, 1'b0, 32'h0,        4'b1111, 32'h12345678};
        vecs[10] = '{32'h102, 32'h0,        3'b010, 1'b1, 1'b0, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[11] = '{32'h101, 32'h0,        3'b001, 1'b1, 1'b0, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[12] = '{32'h202, 32'h55,       3'b010, 1'b0, 1'b1, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[13] = '{32'h100, 32'h0,        3'b011, 1'b1, 1'b0, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[14] = '{32'h200, 32'h77,       3'b100, 1'b0, 1'b1, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[15] = '{32'h100, 32'h0,        3'b010, 1'b1, 1'b1, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0};
        vecs[16] = '{32'h200, 32'h0000BEEF, 3'b001, 1'b0, 1'b1, 32'h0,        1, 1'b0, 32'h0,        4'b0011, 32'hBEEFBEEF};
        vecs[17] = '{32'h100, 32'h0,        3'b000, 1'b1, 1'b0, 32'h000000FF, 0, 1'b0, 32'hFFFFFFFF, 4'b0000, 32'h0};

        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; funct3 = '0;
        memRead = 1'b0; memWrite = 1'b0; memToReg_in = 1'b0; regWrite_in = 1'b0;
        rd_in = '0; dmem_rdata = '0; dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bus", {dmem_req, dmem_we, dmem_wstrb, 26'd0} | dmem_addr | dmem_wdata, 32'd0);
        check("reset_wb", {wb_valid, memToReg, regWrite, rd, mem_fault, stall_out, 22'd0}
                          | data_read | alu_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            cur_id = i;
            run_vec(vecs[i], i);
        end

        // Back-to-back ALU bundles retire every cycle without stalling.
        cur_id = 100;
        for (int i = 1; i <= 3; i++) begin
            exp_t e;
            in_valid = 1'b1; alu_result = 32'(i); store_data = 32'hCAFE0000;
            funct3 = 3'b010; memRead = 1'b0; memWrite = 1'b0;
            memToReg_in = 1'b0; regWrite_in = 1'b1; rd_in = 5'(i + 20);
            e = '{data: 32'h0, alu: 32'(i), m2r: 1'b0, rw: 1'b1, rd: 5'(i + 20),
                  fault: 1'b0, cyc: cyc + 1};
            q.push_back(e);
            check("alu_stall", {31'd0, stall_out}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("alu_stall_end", {31'd0, stall_out}, 32'd0);
        check("alu_no_req", {31'd0, dmem_req}, 32'd0);

        // Reset during BUSY abandons the load with no writeback.
        cur_id = 200;
        in_valid = 1'b1; alu_result = 32'h300; funct3 = 3'b010; memRead = 1'b1;
        memWrite = 1'b0; memToReg_in = 1'b1; regWrite_in = 1'b1; rd_in = 5'd9;
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_req", {31'd0, dmem_req}, 32'd1);
        check("busy_stall", {31'd0, stall_out}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_busy_req", {31'd0, dmem_req}, 32'd0);
        check("rst_busy_stall", {31'd0, stall_out}, 32'd0);
        check("rst_busy_outs", {dmem_we, dmem_wstrb, wb_valid, memToReg, regWrite, rd, mem_fault, 18'd0}
                               | dmem_addr | data_read | alu_data, 32'd0);
        rst_n = 1'b1;
        memRead = 1'b0;
        // Ready in IDLE must be ignored.
        dmem_ready = 1'b1;
        dmem_rdata = 32'h12345678;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready_no_req", {31'd0, dmem_req}, 32'd0);
            check("idle_ready_no_stall", {31'd0, stall_out}, 32'd0);
        end
        dmem_ready = 1'b0;
        repeat (3) @(negedge clk);

        cur_id = 300;
        check("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between execute and writeback.
- Takes the EX/MEM bundle, runs loads and stores on a ready/valid data-memory bus, and aligns and sign-extends load data.
- Drives the registered MEM/WB bundle (data_read, alu_data, memToReg, regWrite, rd) consumed by the writeback mux.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  EX/MEM bundle valid.
- alu_result  in  WIDTH  address for loads/stores; result for ALU ops.
- store_data  in  WIDTH  rs2 value for stores.
- funct3  in  3  access size/sign.
- memRead  in  1  load.
- memWrite  in  1  store.
- memToReg_in  in  1  passed to WB.
- regWrite_in  in  1  passed to WB.
- rd_in  in  5  destination register.
- stall_out  out  1  upstream must hold the bundle.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  WIDTH  word-aligned address.
- dmem_wdata  out  WIDTH  lane-shifted store data.
- dmem_wstrb  out  4  byte strobes.
- dmem_rdata  in  WIDTH  read data.
- dmem_ready  in  1  transfer complete.
- wb_valid  out  1  MEM/WB bundle valid.
- data_read  out  WIDTH  aligned, extended load data.
- alu_data  out  WIDTH  registered alu_result.
- memToReg  out  1  registered memToReg_in.
- regWrite  out  1  registered regWrite_in, forced 0 on fault.
- rd  out  5  registered rd_in.
- mem_fault  out  1  misaligned or illegal access, one cycle with wb_valid.

Behaviour:
- Clock and reset: one clock, clk. Synchronous active-low reset rst_n. On reset: state IDLE; every output is 0, including dmem_* and all MEM/WB outputs.
- FSM has two states, IDLE and BUSY.
- Accept rule: a bundle is accepted on a clk edge when state is IDLE and in_valid=1.
- stall_out = (state==BUSY). It is registered-state driven, with no combinational path from dmem_ready.
- IDLE, no memory op (memRead=memWrite=0): load MEM/WB registers next edge. data_read=0, wb_valid=1. Latency 1. Back-to-back every cycle.
- IDLE, memory op, legal and aligned: capture addr, wdata, wstrb, we, funct3, byte offset and WB fields into internal registers, then go to BUSY. wb_valid=0 that edge.
- BUSY: dmem_req=1 with all dmem_* driven from the internal registers, held stable until completion.
- Completion is the edge where dmem_ready=1. On that edge: load the MEM/WB registers (wb_valid=1, data_read from dmem_rdata), then return to IDLE. The next bundle can be accepted the following cycle.
- Minimum load/store latency is 2 cycles (ready on the first BUSY cycle). Each extra wait cycle adds 1.
- Stores: data_read=0 and dmem_rdata is ignored.
- dmem_ready while in IDLE is ignored.
- Address and strobes:
  - dmem_addr = {alu_result[WIDTH-1:2], 2'b00}; off = alu_result[1:0].
  - SB (000): wstrb = 1<<off; wdata = byte replicated to all 4 lanes.
  - SH (001): wstrb = 0011<<off; wdata = half replicated to both halves.
  - SW (010): wstrb = 1111.
- Loads take lane = rdata >> (8*off):
  - LB=000, sign-extend bits [7:0].
  - LH=001, sign-extend bits [15:0].
  - LW=010, full word.
  - LBU=100, zero-extend bits [7:0].
  - LHU=101, zero-extend bits [15:0].
- Faults are detected in IDLE with no bus request issued:
  - halfword with off[0]=1;
  - word with off≠0;
  - undefined funct3 for the access type;
  - memRead and memWrite both set.
- On a fault: latency-1 writeback with wb_valid=1, mem_fault=1, regWrite=0, data_read=0, alu_data = faulting address.
- wb_valid and mem_fault are single-cycle pulses per bundle.
- Reset asserted during BUSY: next edge returns to IDLE and dmem_req drops to 0. The transaction is abandoned and no wb_valid is produced.
- The upstream stage holds its bundle while stall_out=1. in_valid is ignored in BUSY.

Test Plan:
- LW, addr 0x100, ready on first BUSY cycle, rdata 0xDEADBEEF -> dmem_addr=0x100, wstrb=0, wb_valid 2 cycles after accept, data_read=0xDEADBEEF, memToReg=1.
- LB at 0x103 and LBU at 0x103, rdata 0x80123456 -> data_read 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, store_data 0x0000ABCD, ready after 3 wait cycles -> dmem_we=1, wstrb=1100, wdata=0xABCDABCD; stall_out high 4 cycles; req and addr stable throughout.
- LW at 0x102 -> no dmem_req, wb_valid next cycle, mem_fault=1, regWrite=0, alu_data=0x102.
- Three back-to-back ALU bundles with results 1, 2, 3 -> wb_valid 3 consecutive cycles, alu_data 1, 2, 3, stall_out=0 throughout.
- Load accepted, rst_n=0 during BUSY -> next cycle dmem_req=0, state IDLE, all outputs 0; no wb_valid after reset release until a new bundle arrives.
